instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
- Decoupling FIFO between the instruction memory/PC stage and the decode/controller stage.
- Buffers fetched instruction words together with their PC+4 value, so fetch keeps running while decode stalls.
- Returns back-pressure to fetch when full.
- Discards all buffered instructions on a control-flow redirect (flush).

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears the queue immediately.
- in_instr  input  32  instruction word from fetch.
- in_pcp  input  32  PC+4 of in_instr, from fetch.
- in_valid  input  1  fetch presents a valid word this cycle.
- in_ready  output  1  queue can accept a word this cycle.
- out_instr  output  32  head instruction to decode.
- out_pcp  output  32  PC+4 of the head instruction.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  redirect; discard all entries.
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit entries {instr, pcp}; write pointer wp and read pointer rp, each AW bits, wrap modulo DEPTH; occupancy counter cnt (AW+1 bits).
- Reset (reset=0, asynchronous): wp=0, rp=0, cnt=0; entry contents need not be cleared.
- Outputs while in reset: out_valid=0, in_ready=1, count=0, out_instr=0, out_pcp=0.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (cnt != DEPTH); derived from registered cnt only, with no combinational path from out_ready. A full queue does not accept a push in the same cycle it pops.
- out_valid = (cnt != 0).
- out_instr/out_pcp = entry[rp] when cnt != 0; forced to 32'h0 (NOP / zero) when empty.
- No write-to-read bypass: a word pushed at edge N is visible on out_* after edge N. Minimum latency is 1 cycle.
- Each rising edge, in priority order:
  1. flush=1: wp=0, rp=0, cnt=0; push and pop that cycle are ignored, and the incoming word is dropped.
  2. push & pop: entry[wp]<=in; wp++, rp++; cnt unchanged. Legal whenever 0<cnt<DEPTH.
  3. push only: entry[wp]<=in; wp++; cnt++.
  4. pop only: rp++; cnt--.
  5. Neither: hold.
- Pointer wrap: wp or rp at DEPTH-1 increments to 0; no other wrap handling.
- Empty: out_ready has no effect; cnt never underflows.
- Full: in_valid has no effect; cnt never exceeds DEPTH.
- count = cnt, registered.
- Reset asserted mid-operation: all in-flight entries are lost. After reset deasserts, the first accepted push lands at entry 0.
- FIFO order: instructions leave in exactly the order accepted; the pcp stays paired with its own instr.

Test Plan:
- Reset, then in_valid=0 for 3 cycles -> out_valid=0, in_ready=1, count=0, out_instr=0.
- Push 0x3c010001/pcp 0x3004, out_ready=0 -> next cycle out_valid=1, out_instr=0x3c010001, out_pcp=0x3004, count=1. Raise out_ready -> queue empties next cycle.
- Push 6 consecutive words (pcp 0x3004..0x3018) with out_ready=0 -> in_ready drops after the 4th accept and count=4. Then drain with out_ready=1 -> pops return pcp 0x3004, 0x3008, 0x300c, 0x3010 in order. Only those four were accepted; the 5th and 6th were refused.
- Steady stream with in_valid=1 and out_ready=1 for 10 cycles from count=1 -> count stays 1, and pointers wrap past entry 3 without loss or reorder.
- count=3, then flush=1 in the same cycle as in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. Next pushed word (pcp 0x3100) is the head.
- count=2, then drive reset=0 between clock edges -> out_valid=0 and count=0 immediately, before the next edge. After release, push pcp 0x3004 -> it appears at the head.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: decouples fetch from decode.
// Buffers {instr, pc+4} pairs in a small circular FIFO, back-pressures fetch
// when full and drops all buffered words on a control-flow redirect (flush).
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pcp,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pcp,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  // DEPTH must be a power of two, at least 2, with AW = log2(DEPTH)
  if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_bad_depth
    $error("instr_fetch_queue: DEPTH must be a power of two >= 2 and equal 2**AW");
  end

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Handshake qualifiers; in_ready comes only from registered cnt
  always_comb begin
    in_ready  = (cnt != FULL_CNT);
    out_valid = (cnt != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Head entry, forced to zero (NOP) while empty
  always_comb begin
    head = mem[rp];
    if (cnt == '0) begin
      out_instr = '0;
      out_pcp   = '0;
    end else begin
      out_instr = head[63:32];
      out_pcp   = head[31:0];
    end
  end

  assign count = cnt;

  // Entry storage; no reset needed, a flush suppresses the write
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wp] <= {in_instr, in_pcp};
    end
  end

  // Pointer and occupancy update; flush outranks any push/pop that cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

endmodule
